// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: next-PC selection, icache miss refill sequencing and
// redirect buffering while a refill line is in flight.
module fetch_ctrl #(
    parameter int unsigned          PC_SIZE    = 32,
    parameter logic [PC_SIZE-1:0]   RESET_PC   = '0,
    parameter int unsigned          LINE_WORDS = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ic_hit,
    input  logic                          id_stall,
    input  logic                          ex_redirect,
    input  logic [PC_SIZE-1:0]            ex_target,
    input  logic                          id_redirect,
    input  logic [PC_SIZE-1:0]            id_target,
    input  logic                          pd_take,
    input  logic [PC_SIZE-1:0]            pd_target,
    input  logic                          mem_ack,
    input  logic                          mem_valid,
    output logic [PC_SIZE-1:0]            pc,
    output logic                          if_valid,
    output logic                          nop_sel,
    output logic                          mem_req,
    output logic [PC_SIZE-1:0]            mem_addr,
    output logic                          fill_we,
    output logic [$clog2(LINE_WORDS)-1:0] fill_idx
);

    localparam int unsigned IDX_W = $clog2(LINE_WORDS);
    localparam int unsigned OFF_W = IDX_W + 2;

    typedef enum logic [1:0] {StRun, StReq, StFill} state_e;

    state_e             state_q, state_d;
    logic [PC_SIZE-1:0] pc_q, pc_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               pend_valid_q, pend_valid_d;
    logic               pend_ex_q, pend_ex_d;
    logic [PC_SIZE-1:0] pend_target_q, pend_target_d;

    logic               redir;
    logic [PC_SIZE-1:0] redir_target;

    assign redir        = ex_redirect | id_redirect;
    assign redir_target = ex_redirect ? ex_target : id_target;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        idx_d         = idx_q;
        pend_valid_d  = pend_valid_q;
        pend_ex_d     = pend_ex_q;
        pend_target_d = pend_target_q;

        case (state_q)
            StRun: begin
                if (redir) begin
                    pc_d = redir_target;
                end else if (!ic_hit) begin
                    state_d = StReq;
                end else if (!id_stall) begin
                    pc_d = pd_take ? pd_target : pc_q + PC_SIZE'(4);
                end
            end
            StReq: begin
                if (redir) begin
                    pc_d    = redir_target;
                    state_d = StRun;
                end else if (mem_ack) begin
                    state_d = StFill;
                    idx_d   = '0;
                end
            end
            StFill: begin
                // A buffered ex redirect outranks any later id redirect.
                if (ex_redirect) begin
                    pend_valid_d  = 1'b1;
                    pend_ex_d     = 1'b1;
                    pend_target_d = ex_target;
                end else if (id_redirect && !(pend_valid_q && pend_ex_q)) begin
                    pend_valid_d  = 1'b1;
                    pend_ex_d     = 1'b0;
                    pend_target_d = id_target;
                end
                if (mem_valid) begin
                    if (idx_q == IDX_W'(LINE_WORDS - 1)) begin
                        state_d = StRun;
                        idx_d   = '0;
                        if (pend_valid_d) begin
                            pc_d = pend_target_d;
                        end
                        pend_valid_d = 1'b0;
                        pend_ex_d    = 1'b0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StRun;
            pc_q          <= RESET_PC;
            idx_q         <= '0;
            pend_valid_q  <= 1'b0;
            pend_ex_q     <= 1'b0;
            pend_target_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            idx_q         <= idx_d;
            pend_valid_q  <= pend_valid_d;
            pend_ex_q     <= pend_ex_d;
            pend_target_q <= pend_target_d;
        end
    end

    // Strobes are also gated by rst so they drop the instant reset asserts.
    assign pc       = pc_q;
    assign if_valid = (state_q == StRun) & ic_hit & ~redir & ~rst;
    assign nop_sel  = redir;
    assign mem_req  = (state_q == StReq) & ~rst;
    assign mem_addr = {pc_q[PC_SIZE-1:OFF_W], OFF_W'(0)};
    assign fill_we  = (state_q == StFill) & mem_valid & ~rst;
    assign fill_idx = idx_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl; refill writes are checked against a scoreboard of
// expected fill indices pushed whenever a refill word is driven.
module tb_fetch_ctrl;

    logic        clk, rst;
    logic        ic_hit, id_stall;
    logic        ex_redirect, id_redirect, pd_take;
    logic [31:0] ex_target, id_target, pd_target;
    logic        mem_ack, mem_valid;
    logic [31:0] pc, mem_addr;
    logic        if_valid, nop_sel, mem_req, fill_we;
    logic [1:0]  fill_idx;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] fill_q[$];

    fetch_ctrl #(.PC_SIZE(32), .RESET_PC(32'h0), .LINE_WORDS(4)) dut (
        .clk(clk), .rst(rst), .ic_hit(ic_hit), .id_stall(id_stall),
        .ex_redirect(ex_redirect), .ex_target(ex_target),
        .id_redirect(id_redirect), .id_target(id_target),
        .pd_take(pd_take), .pd_target(pd_target),
        .mem_ack(mem_ack), .mem_valid(mem_valid),
        .pc(pc), .if_valid(if_valid), .nop_sel(nop_sel),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .fill_we(fill_we), .fill_idx(fill_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctl();
        ex_redirect = 0; id_redirect = 0; pd_take = 0;
        mem_ack = 0; mem_valid = 0; id_stall = 0;
    endtask

    task automatic fill_word(input int idx);
        fill_q.push_back(32'(idx));
        mem_valid = 1;
        #1;
        check("fill_we_on", {31'b0, fill_we}, 1);
        tick();
        mem_valid = 0;
    endtask

    // Scoreboard side: every icache write must match the next expected index.
    always @(negedge clk) begin
        if (fill_we) begin
            if (fill_q.size() == 0) check("fill_unexp", 1, 0);
            else check("fill_idx", {30'b0, fill_idx}, fill_q.pop_front());
        end
    end

    initial begin
        rst = 1; ic_hit = 1;
        ex_target = 0; id_target = 0; pd_target = 0;
        clear_ctl();
        tick(); tick();
        check("rst_pc", pc, 0);
        check("rst_if_valid", {31'b0, if_valid}, 0);
        check("rst_mem_req", {31'b0, mem_req}, 0);

        // Sequential fetch after reset release
        rst = 0;
        #1;
        check("first_pc", pc, 0);
        check("first_if_valid", {31'b0, if_valid}, 1);
        tick(); check("seq_pc4", pc, 32'h4);
        tick(); check("seq_pc8", pc, 32'h8);

        // id redirect wins over pd_take
        id_redirect = 1; id_target = 32'h10;
        tick(); clear_ctl();
        check("redir_pc10", pc, 32'h10);
        pd_take = 1; pd_target = 32'h40; id_redirect = 1; id_target = 32'h80;
        #1;
        check("prio_nop_sel", {31'b0, nop_sel}, 1);
        check("prio_if_valid", {31'b0, if_valid}, 0);
        tick(); clear_ctl();
        check("prio_pc", pc, 32'h80);

        // Stall holds pc, then predicted-taken branch
        id_stall = 1; pd_take = 1; pd_target = 32'h24;
        tick();
        check("stall_pc", pc, 32'h80);
        id_stall = 0;
        tick(); clear_ctl();
        check("pd_take_pc", pc, 32'h24);

        // Miss and full refill
        ic_hit = 0;
        #1;
        check("miss_if_valid", {31'b0, if_valid}, 0);
        tick();
        check("req_mem_req", {31'b0, mem_req}, 1);
        check("req_mem_addr", mem_addr, 32'h20);
        tick();
        check("req_hold_addr", mem_addr, 32'h20);
        check("req_hold_pc", pc, 32'h24);
        mem_ack = 1;
        tick(); mem_ack = 0;
        check("fill_mem_req", {31'b0, mem_req}, 0);
        fill_word(0);
        fill_word(1);
        #1;
        check("fill_gap_we", {31'b0, fill_we}, 0);
        tick();
        fill_word(2);
        fill_word(3);
        check("fill_exit_pc", pc, 32'h24);
        ic_hit = 1;
        #1;
        check("fill_exit_if_valid", {31'b0, if_valid}, 1);

        // Redirects during refill are buffered; ex outranks later id
        ic_hit = 0;
        tick();
        mem_ack = 1;
        tick(); mem_ack = 0;
        fill_word(0);
        fill_word(1);
        ic_hit = 1;
        ex_redirect = 1; ex_target = 32'h100;
        #1;
        check("fill_if_valid", {31'b0, if_valid}, 0);
        tick(); clear_ctl();
        id_redirect = 1; id_target = 32'h200;
        tick(); clear_ctl();
        check("fill_pc_hold", pc, 32'h24);
        ic_hit = 0;
        fill_word(2);
        fill_word(3);
        check("pend_pc", pc, 32'h100);

        // Redirect beats mem_ack in REQ
        tick();
        check("req2_mem_req", {31'b0, mem_req}, 1);
        ex_redirect = 1; ex_target = 32'h300; mem_ack = 1;
        tick(); clear_ctl();
        check("abort_pc", pc, 32'h300);
        check("abort_mem_req", {31'b0, mem_req}, 0);
        ic_hit = 1; mem_valid = 1;
        tick(); tick();
        mem_valid = 0;
        check("abort_pc_run", pc, 32'h308);

        // PC wrap
        id_redirect = 1; id_target = 32'hFFFF_FFFC;
        tick(); clear_ctl();
        check("wrap_pre", pc, 32'hFFFF_FFFC);
        tick();
        check("wrap_pc", pc, 32'h0);

        // Async reset mid-refill
        ic_hit = 0;
        tick();
        mem_ack = 1;
        tick(); mem_ack = 0;
        fill_word(0);
        mem_valid = 1;
        rst = 1;
        #1;
        check("rst_fill_we", {31'b0, fill_we}, 0);
        check("rst_fill_pc", pc, 0);
        tick(); clear_ctl();
        ic_hit = 1;
        rst = 0;
        #1;
        check("rst2_if_valid", {31'b0, if_valid}, 1);
        tick();
        check("rst2_pc", pc, 32'h4);

        check("fill_left", 32'(fill_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter PC_SIZE, default 32, PC and address width in bits.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-003 Parameter LINE_WORDS, default 4 (power of 2, 2..16), 32-bit words per icache refill line.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  asynchronous reset, active-high.
REQ-006 ic_hit  in  1  icache holds the line addressed by pc this cycle.
REQ-007 id_stall  in  1  decode cannot accept an instruction this cycle.
REQ-008 ex_redirect / ex_target  in  1 / PC_SIZE  branch mispredict correction (bxx fail).
REQ-009 id_redirect / id_target  in  1 / PC_SIZE  jalr target resolved in decode.
REQ-010 pd_take / pd_target  in  1 / PC_SIZE  predecode predicted-taken branch/jal.
REQ-011 mem_ack / mem_valid  in  1 / 1  refill request accepted / one refill word returned.
REQ-012 pc  out  PC_SIZE  current fetch address.
REQ-013 if_valid / nop_sel  out  1 / 1  instruction to decode is valid / squash it to INSTR_NOP.
REQ-014 mem_req / mem_addr  out  1 / PC_SIZE  refill request, line-aligned address.
REQ-015 fill_we / fill_idx  out  1 / log2(LINE_WORDS)  icache fill write strobe and word index.

Function
REQ-016 States SHALL be RUN, REQ, FILL.
REQ-017 Next-PC priority SHALL be ex_redirect > id_redirect > pd_take > pc+4.
REQ-018 In RUN, ex_redirect or id_redirect SHALL load pc with its target on the next edge regardless of id_stall and ic_hit.
REQ-019 In RUN with no ex/id redirect, ic_hit=1 and id_stall=0, pc SHALL load pd_target if pd_take else pc+4 (wraps modulo 2^PC_SIZE).
REQ-020 In RUN with ic_hit=1 and id_stall=1 and no ex/id redirect, pc SHALL hold.
REQ-021 In RUN with ic_hit=0 and no ex/id redirect, state SHALL go to REQ, pc holds.
REQ-022 if_valid SHALL be 1 only when state=RUN, ic_hit=1, ex_redirect=0, id_redirect=0 and rst=0.
REQ-023 nop_sel SHALL equal ex_redirect|id_redirect in any state.
REQ-024 In REQ, mem_req SHALL be 1 and mem_addr SHALL be pc with low log2(LINE_WORDS)+2 bits cleared; both stable until mem_ack.
REQ-025 In REQ, mem_ack=1 with no ex/id redirect SHALL move to FILL with fill_idx=0.
REQ-026 In REQ, ex/id redirect SHALL abort the request (mem_req 0 next cycle), load pc with the target, return to RUN; redirect wins over simultaneous mem_ack.
REQ-027 In FILL, fill_we SHALL equal mem_valid and fill_idx SHALL increment by 1 on each mem_valid.
REQ-028 In FILL, mem_valid with fill_idx=LINE_WORDS-1 SHALL return to RUN and reset fill_idx to 0.
REQ-029 In FILL, ex/id redirect SHALL NOT abort the refill; highest-priority target SHALL be latched in a one-entry pending register (later higher-priority redirects overwrite, lower ones ignored).
REQ-030 On FILL exit with pending valid, pc SHALL load the pending target and pending SHALL clear in the same edge; otherwise pc holds.
REQ-031 pd_take SHALL be ignored outside RUN or when ic_hit=0.
REQ-032 fill_we SHALL be 0 outside FILL; mem_req SHALL be 0 outside REQ.

Reset
REQ-033 While rst=1: pc=RESET_PC, state=RUN, fill_idx=0, pending cleared, mem_req=0, fill_we=0, if_valid=0.
REQ-034 rst asserted mid-REQ or mid-FILL SHALL drop mem_req/fill_we immediately (asynchronously), with no further icache writes.
REQ-035 After rst deasserts, first fetch SHALL be at RESET_PC.

Verification
REQ-036 Reset release, ic_hit=1, no stall -> pc 0x0,0x4,0x8 on consecutive edges, if_valid=1.
REQ-037 RUN at pc=0x10, pd_take=1 pd_target=0x40 and id_redirect=1 id_target=0x80 same cycle -> pc=0x80, nop_sel=1, if_valid=0.
REQ-038 pc=0x24, ic_hit=0 -> REQ, mem_addr=0x20; mem_ack; 4 mem_valid -> fill_idx 0..3 with fill_we, RUN, pc=0x24.
REQ-039 In FILL after word 1, ex_redirect target 0x100, then id_redirect 0x200 -> refill completes 4 words, pc=0x100 on exit.
REQ-040 In REQ, ex_redirect 0x300 with mem_ack same cycle -> RUN, pc=0x300, mem_req=0, no fill_we.
REQ-041 pc=0xFFFF_FFFC, hit, no stall -> pc wraps to 0x0.
